// File: rtl/ddc_frame_packer.sv
// ddc_frame_packer: frames N_CH-beat DDC bursts into header+data packets behind a
// commit-pointer FIFO feeding an AXI-Stream master. Define DDC_TRAILER_EN for a count trailer.
module ddc_frame_packer #(
   parameter int N_CH       = 4,
   parameter int FIFO_DEPTH = 64
) (
   input  logic        dev_clk,
   input  logic        dev_rst,
   input  logic [63:0] s_axis_ddc_tdata,
   input  logic        s_axis_ddc_tvalid,
   input  logic        enable,
   output logic [63:0] m_axis_tdata,
   output logic        m_axis_tvalid,
   input  logic        m_axis_tready,
   output logic        m_axis_tlast,
   output logic [31:0] frame_cnt,
   output logic [31:0] drop_cnt,
   output logic [31:0] err_cnt
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int PW = AW + 1;
`ifdef DDC_TRAILER_EN
   localparam int  PKT_LEN    = N_CH + 2;
   localparam logic LP_FLUSH_LAST = 1'b0;
`else
   localparam int  PKT_LEN    = N_CH + 1;
   localparam logic LP_FLUSH_LAST = 1'b1;
`endif
   localparam logic [PW:0] LP_DEPTH = (PW+1)'(FIFO_DEPTH);
   localparam logic [PW:0] LP_NEED  = (PW+1)'(PKT_LEN);
   localparam logic [8:0]  LP_NCH   = 9'(N_CH);
   localparam logic [15:0] LP_NCH16 = 16'(N_CH);

`ifdef DDC_TRAILER_EN
   typedef enum logic [2:0] {
      S_IDLE, S_COLLECT, S_FLUSH, S_TRAILER, S_SKIP
   } state_t;
`else
   typedef enum logic [1:0] {
      S_IDLE, S_COLLECT, S_FLUSH, S_SKIP
   } state_t;
`endif

   state_t      r_state;
   logic [AW:0] r_wr_ptr;
   logic [AW:0] r_commit_ptr;
   logic [AW:0] r_rd_ptr;
   logic [63:0] r_stage;
   logic [8:0]  r_beat_idx;
   logic [31:0] r_frame_cnt;
   logic [31:0] r_drop_cnt;
   logic [31:0] r_err_cnt;
   logic [64:0] r_mem [FIFO_DEPTH];
   logic [63:0] r_tdata;
   logic        r_tvalid;
   logic        r_tlast;
`ifdef DDC_TRAILER_EN
   logic [63:0] r_trailer;
   logic        r_ovr;
`endif

   logic [PW:0] w_free;
   logic        w_fits;
   logic        w_we;
   logic [64:0] w_wdata;
   logic        w_rd;
   logic [63:0] w_beat;
   logic [63:0] w_header;
   logic        w_unused;

   // Q and I are 30-bit two's complement; widen each to 32 bits
   assign w_beat = {{2{s_axis_ddc_tdata[61]}}, s_axis_ddc_tdata[61:32],
                    {2{s_axis_ddc_tdata[29]}}, s_axis_ddc_tdata[29:0]};
   assign w_unused = ^{s_axis_ddc_tdata[63:62], s_axis_ddc_tdata[31:30]};

   assign w_header = {16'hDDC0, LP_NCH16, r_frame_cnt};
   assign w_free   = LP_DEPTH - {1'b0, r_wr_ptr - r_rd_ptr};
   assign w_fits   = (w_free >= LP_NEED);

   always_comb begin
      w_we    = 1'b0;
      w_wdata = '0;
      unique case (r_state)
         S_IDLE: begin
            w_we    = s_axis_ddc_tvalid & enable & w_fits;
            w_wdata = {1'b0, w_header};
         end
         S_COLLECT: begin
            w_we    = 1'b1;
            w_wdata = {1'b0, r_stage};
         end
         S_FLUSH: begin
            w_we    = 1'b1;
            w_wdata = {LP_FLUSH_LAST, r_stage};
         end
`ifdef DDC_TRAILER_EN
         S_TRAILER: begin
            w_we    = 1'b1;
            w_wdata = {1'b1, r_trailer};
         end
`endif
         default: begin
            w_we    = 1'b0;
            w_wdata = '0;
         end
      endcase
   end

   always_ff @(posedge dev_clk) begin
      if (w_we) r_mem[r_wr_ptr[AW-1:0]] <= w_wdata;
   end

   always_ff @(posedge dev_clk) begin
      if (dev_rst) begin
         r_state      <= S_IDLE;
         r_wr_ptr     <= '0;
         r_commit_ptr <= '0;
         r_stage      <= '0;
         r_beat_idx   <= '0;
         r_frame_cnt  <= '0;
         r_drop_cnt   <= '0;
         r_err_cnt    <= '0;
`ifdef DDC_TRAILER_EN
         r_trailer    <= '0;
         r_ovr        <= 1'b0;
`endif
      end else begin
         if (w_we) r_wr_ptr <= r_wr_ptr + 1'b1;
         unique case (r_state)
            S_IDLE: begin
               if (s_axis_ddc_tvalid) begin
                  r_frame_cnt <= r_frame_cnt + 32'd1;
                  r_stage     <= w_beat;
                  r_beat_idx  <= 9'd1;
                  if (!enable) begin
                     r_state <= S_SKIP;
                  end else if (w_fits) begin
                     r_state <= (LP_NCH == 9'd1) ? S_FLUSH : S_COLLECT;
                  end else begin
                     r_drop_cnt <= r_drop_cnt + 32'd1;
                     r_state    <= S_SKIP;
                  end
               end
            end
            S_COLLECT: begin
               if (s_axis_ddc_tvalid) begin
                  r_stage    <= w_beat;
                  r_beat_idx <= r_beat_idx + 9'd1;
                  if (r_beat_idx + 9'd1 == LP_NCH) r_state <= S_FLUSH;
               end else begin
                  // truncated burst: rewind so nothing of it is ever readable
                  r_wr_ptr  <= r_commit_ptr;
                  r_err_cnt <= r_err_cnt + 32'd1;
                  r_state   <= S_IDLE;
               end
            end
`ifdef DDC_TRAILER_EN
            S_FLUSH: begin
               r_trailer <= {r_drop_cnt, r_err_cnt};
               r_ovr     <= s_axis_ddc_tvalid;
               if (s_axis_ddc_tvalid) r_err_cnt <= r_err_cnt + 32'd1;
               r_state <= S_TRAILER;
            end
            S_TRAILER: begin
               r_commit_ptr <= r_wr_ptr + 1'b1;
               if (s_axis_ddc_tvalid && !r_ovr) r_err_cnt <= r_err_cnt + 32'd1;
               r_state <= s_axis_ddc_tvalid ? S_SKIP : S_IDLE;
            end
`else
            S_FLUSH: begin
               r_commit_ptr <= r_wr_ptr + 1'b1;
               if (s_axis_ddc_tvalid) begin
                  r_err_cnt <= r_err_cnt + 32'd1;
                  r_state   <= S_SKIP;
               end else begin
                  r_state   <= S_IDLE;
               end
            end
`endif
            S_SKIP: begin
               if (!s_axis_ddc_tvalid) r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // Output stage reads only committed words
   assign w_rd = (r_rd_ptr != r_commit_ptr) && (!r_tvalid || m_axis_tready);

   always_ff @(posedge dev_clk) begin
      if (dev_rst) begin
         r_rd_ptr <= '0;
         r_tvalid <= 1'b0;
         r_tlast  <= 1'b0;
         r_tdata  <= '0;
      end else if (w_rd) begin
         {r_tlast, r_tdata} <= r_mem[r_rd_ptr[AW-1:0]];
         r_tvalid <= 1'b1;
         r_rd_ptr <= r_rd_ptr + 1'b1;
      end else if (m_axis_tready) begin
         r_tvalid <= 1'b0;
      end
   end

   assign m_axis_tdata  = r_tdata;
   assign m_axis_tvalid = r_tvalid;
   assign m_axis_tlast  = r_tlast;
   assign frame_cnt     = r_frame_cnt;
   assign drop_cnt      = r_drop_cnt;
   assign err_cnt       = r_err_cnt;

endmodule

// File: tb/tb_ddc_frame_packer.sv
// tb_ddc_frame_packer: randomized frame stimulus against a queue-based packet model.
module tb_ddc_frame_packer;

   localparam int N_CH  = 4;
   localparam int DEPTH = 64;
`ifdef DDC_TRAILER_EN
   localparam int PKT = N_CH + 2;
   localparam int GAP = 2;
   localparam int LAT = 4;
`else
   localparam int PKT = N_CH + 1;
   localparam int GAP = 1;
   localparam int LAT = 3;
`endif

   logic        dev_clk = 1'b0;
   logic        dev_rst;
   logic [63:0] s_axis_ddc_tdata;
   logic        s_axis_ddc_tvalid;
   logic        enable;
   logic [63:0] m_axis_tdata;
   logic        m_axis_tvalid;
   logic        m_axis_tready;
   logic        m_axis_tlast;
   logic [31:0] frame_cnt;
   logic [31:0] drop_cnt;
   logic [31:0] err_cnt;

   always #5 dev_clk = ~dev_clk;

   ddc_frame_packer #(.N_CH(N_CH), .FIFO_DEPTH(DEPTH)) dut (
      .dev_clk          (dev_clk),
      .dev_rst          (dev_rst),
      .s_axis_ddc_tdata (s_axis_ddc_tdata),
      .s_axis_ddc_tvalid(s_axis_ddc_tvalid),
      .enable           (enable),
      .m_axis_tdata     (m_axis_tdata),
      .m_axis_tvalid    (m_axis_tvalid),
      .m_axis_tready    (m_axis_tready),
      .m_axis_tlast     (m_axis_tlast),
      .frame_cnt        (frame_cnt),
      .drop_cnt         (drop_cnt),
      .err_cnt          (err_cnt)
   );

   logic [64:0] exp_q[$];
   logic [64:0] got_q[$];
   logic [63:0] cur_beats[$];
   int n_checks = 0;
   int n_fail   = 0;
   int m_frame  = 0;
   int m_drop   = 0;
   int m_err    = 0;
   bit rand_ready = 1'b0;

   always @(posedge dev_clk)
      if (!dev_rst && m_axis_tvalid && m_axis_tready)
         got_q.push_back({m_axis_tlast, m_axis_tdata});

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge dev_clk);
      #1;
      if (rand_ready) m_axis_tready = ($urandom_range(0, 3) != 0);
   endtask

   function automatic logic [63:0] mk_raw(input int i, input int q);
      logic [29:0] i30;
      logic [29:0] q30;
      i30 = i[29:0];
      q30 = q[29:0];
      return {2'b10, q30, 2'b01, i30};
   endfunction

   function automatic logic [63:0] rand_raw();
      return {$urandom(), $urandom()};
   endfunction

   function automatic logic [63:0] fmt(input logic [63:0] raw);
      int qv;
      int iv;
      qv = int'($signed(raw[61:32]));
      iv = int'($signed(raw[29:0]));
      return {qv, iv};
   endfunction

   function automatic bit model_fits();
      int pend;
      int used;
      pend = exp_q.size() - got_q.size();
      used = (pend > 0) ? pend - 1 : 0;
      return (DEPTH - used) >= PKT;
   endfunction

   task automatic model_frame(input bit en, input bit fits);
      int n;
      logic [31:0] hdr;
      logic lst;
      n = cur_beats.size();
      hdr = m_frame;
      m_frame++;
      if (!en) return;
      if (!fits) begin
         m_drop++;
         return;
      end
      if (n < N_CH) begin
         m_err++;
         return;
      end
      exp_q.push_back({1'b0, 16'hDDC0, 16'(N_CH), hdr});
      for (int k = 0; k < N_CH; k++) begin
         lst = (k == N_CH - 1) && (PKT == N_CH + 1);
         exp_q.push_back({lst, fmt(cur_beats[k])});
      end
`ifdef DDC_TRAILER_EN
      exp_q.push_back({1'b1, m_drop, m_err});
`endif
      if (n > N_CH) m_err++;
   endtask

   task automatic drive_beats(input bit en);
      enable = en;
      foreach (cur_beats[k]) begin
         s_axis_ddc_tdata  = cur_beats[k];
         s_axis_ddc_tvalid = 1'b1;
         tick();
      end
      s_axis_ddc_tvalid = 1'b0;
      s_axis_ddc_tdata  = rand_raw();
   endtask

   task automatic send_frame(input int n, input int gap, input bit en);
      bit fits;
      fits = model_fits();
      cur_beats.delete();
      for (int k = 0; k < n; k++) cur_beats.push_back(rand_raw());
      model_frame(en, fits);
      drive_beats(en);
      repeat (gap) tick();
   endtask

   task automatic drain();
      int t;
      rand_ready = 1'b0;
      m_axis_tready = 1'b1;
      t = 0;
      while (got_q.size() < exp_q.size() && t < 3000) begin
         tick();
         t++;
      end
      repeat (6) tick();
   endtask

   task automatic test_reset();
      dev_rst = 1'b1;
      s_axis_ddc_tvalid = 1'b0;
      s_axis_ddc_tdata = '0;
      enable = 1'b1;
      m_axis_tready = 1'b1;
      repeat (3) tick();
      dev_rst = 1'b0;
      tick();
      n_checks += 6;
      if (m_axis_tvalid !== 1'b0) begin
         n_fail++; $display("FAIL rst_tvalid: got %b expected 0", m_axis_tvalid);
      end
      if (m_axis_tlast !== 1'b0) begin
         n_fail++; $display("FAIL rst_tlast: got %b expected 0", m_axis_tlast);
      end
      if (m_axis_tdata !== 64'd0) begin
         n_fail++; $display("FAIL rst_tdata: got %h expected 0", m_axis_tdata);
      end
      if (frame_cnt !== 32'd0) begin
         n_fail++; $display("FAIL rst_frame_cnt: got %0d expected 0", frame_cnt);
      end
      if (drop_cnt !== 32'd0) begin
         n_fail++; $display("FAIL rst_drop_cnt: got %0d expected 0", drop_cnt);
      end
      if (err_cnt !== 32'd0) begin
         n_fail++; $display("FAIL rst_err_cnt: got %0d expected 0", err_cnt);
      end
   endtask

   task automatic test_single_frame();
      int iv[4];
      iv = '{1, -1, 536870911, -536870912};
      m_axis_tready = 1'b1;
      cur_beats.delete();
      for (int k = 0; k < N_CH; k++) cur_beats.push_back(mk_raw(iv[k], -iv[k]));
      model_frame(1'b1, model_fits());
      drive_beats(1'b1);
      repeat (LAT - 2) tick();
      n_checks++;
      if (m_axis_tvalid !== 1'b0) begin
         n_fail++; $display("FAIL single_early: tvalid got %b expected 0", m_axis_tvalid);
      end
      tick();
      n_checks++;
      if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 64'hDDC0_0004_0000_0000) begin
         n_fail++;
         $display("FAIL single_latency: got v=%b %h expected v=1 %h",
                  m_axis_tvalid, m_axis_tdata, 64'hDDC0_0004_0000_0000);
      end
      drain();
      n_checks++;
      if (got_q.size() !== exp_q.size()) begin
         n_fail++; $display("FAIL single_count: got %0d expected %0d", got_q.size(), exp_q.size());
      end
      foreach (exp_q[i]) begin
         n_checks++;
         if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
            n_fail++;
            $display("FAIL single_word%0d: got %h expected %h", i,
                     (i < got_q.size()) ? got_q[i] : 65'h0, exp_q[i]);
         end
      end
      n_checks++;
      if (frame_cnt !== 32'(m_frame)) begin
         n_fail++; $display("FAIL single_frame_cnt: got %0d expected %0d", frame_cnt, m_frame);
      end
      exp_q.delete();
      got_q.delete();
   endtask

   task automatic test_back_to_back();
      logic [63:0] held;
      m_axis_tready = 1'b0;
      repeat (10) send_frame(N_CH, GAP, 1'b1);
      repeat (4) tick();
      held = m_axis_tdata;
      repeat (3) tick();
      n_checks += 2;
      if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== exp_q[0][63:0]) begin
         n_fail++;
         $display("FAIL b2b_head: got v=%b %h expected v=1 %h",
                  m_axis_tvalid, m_axis_tdata, exp_q[0][63:0]);
      end
      if (m_axis_tdata !== held) begin
         n_fail++; $display("FAIL b2b_hold: got %h expected %h", m_axis_tdata, held);
      end
      n_checks++;
      if (frame_cnt !== 32'(m_frame)) begin
         n_fail++; $display("FAIL b2b_frame_cnt: got %0d expected %0d", frame_cnt, m_frame);
      end
      drain();
      n_checks++;
      if (got_q.size() !== exp_q.size()) begin
         n_fail++; $display("FAIL b2b_count: got %0d expected %0d", got_q.size(), exp_q.size());
      end
      foreach (exp_q[i]) begin
         n_checks++;
         if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
            n_fail++;
            $display("FAIL b2b_word%0d: got %h expected %h", i,
                     (i < got_q.size()) ? got_q[i] : 65'h0, exp_q[i]);
         end
      end
      exp_q.delete();
      got_q.delete();
   endtask

   task automatic test_drop();
      int d0;
      d0 = m_drop;
      m_axis_tready = 1'b0;
      for (int f = 0; f < 20; f++) begin
         if (m_drop != d0) break;
         send_frame(N_CH, 4, 1'b1);
      end
      repeat (4) tick();
      n_checks += 2;
      if (drop_cnt !== 32'(m_drop)) begin
         n_fail++; $display("FAIL drop_cnt: got %0d expected %0d", drop_cnt, m_drop);
      end
      if (frame_cnt !== 32'(m_frame)) begin
         n_fail++; $display("FAIL drop_frame_cnt: got %0d expected %0d", frame_cnt, m_frame);
      end
      drain();
      send_frame(N_CH, GAP, 1'b1);
      drain();
      n_checks++;
      if (got_q.size() !== exp_q.size()) begin
         n_fail++; $display("FAIL drop_count: got %0d expected %0d", got_q.size(), exp_q.size());
      end
      foreach (exp_q[i]) begin
         n_checks++;
         if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
            n_fail++;
            $display("FAIL drop_word%0d: got %h expected %h", i,
                     (i < got_q.size()) ? got_q[i] : 65'h0, exp_q[i]);
         end
      end
      exp_q.delete();
      got_q.delete();
   endtask

   task automatic test_truncation();
      m_axis_tready = 1'b1;
      send_frame(2, 3, 1'b1);
      repeat (6) tick();
      n_checks += 3;
      if (got_q.size() !== 0 || m_axis_tvalid !== 1'b0) begin
         n_fail++;
         $display("FAIL trunc_emit: got %0d words v=%b expected 0 words v=0",
                  got_q.size(), m_axis_tvalid);
      end
      if (err_cnt !== 32'(m_err)) begin
         n_fail++; $display("FAIL trunc_err_cnt: got %0d expected %0d", err_cnt, m_err);
      end
      if (frame_cnt !== 32'(m_frame)) begin
         n_fail++; $display("FAIL trunc_frame_cnt: got %0d expected %0d", frame_cnt, m_frame);
      end
      send_frame(N_CH, GAP, 1'b1);
      drain();
      n_checks++;
      if (got_q.size() !== exp_q.size()) begin
         n_fail++; $display("FAIL trunc_count: got %0d expected %0d", got_q.size(), exp_q.size());
      end
      foreach (exp_q[i]) begin
         n_checks++;
         if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
            n_fail++;
            $display("FAIL trunc_word%0d: got %h expected %h", i,
                     (i < got_q.size()) ? got_q[i] : 65'h0, exp_q[i]);
         end
      end
      exp_q.delete();
      got_q.delete();
   endtask

   task automatic test_overrun();
      m_axis_tready = 1'b1;
      send_frame(N_CH + 2, GAP + 1, 1'b1);
      drain();
      n_checks += 3;
      if (err_cnt !== 32'(m_err)) begin
         n_fail++; $display("FAIL ovr_err_cnt: got %0d expected %0d", err_cnt, m_err);
      end
      if (frame_cnt !== 32'(m_frame)) begin
         n_fail++; $display("FAIL ovr_frame_cnt: got %0d expected %0d", frame_cnt, m_frame);
      end
      if (got_q.size() !== exp_q.size()) begin
         n_fail++; $display("FAIL ovr_count: got %0d expected %0d", got_q.size(), exp_q.size());
      end
      foreach (exp_q[i]) begin
         n_checks++;
         if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
            n_fail++;
            $display("FAIL ovr_word%0d: got %h expected %h", i,
                     (i < got_q.size()) ? got_q[i] : 65'h0, exp_q[i]);
         end
      end
      exp_q.delete();
      got_q.delete();
   endtask

   task automatic test_random();
      int t;
      int n;
      bit en;
      rand_ready = 1'b1;
      for (int f = 0; f < 40; f++) begin
         t = 0;
         while ((exp_q.size() - got_q.size()) > DEPTH - 2 * PKT && t < 500) begin
            tick();
            t++;
         end
         en = ($urandom_range(0, 4) != 0);
         n = ($urandom_range(0, 7) == 0) ? $urandom_range(1, N_CH - 1) : N_CH;
         send_frame(n, GAP + $urandom_range(0, 3), en);
      end
      drain();
      n_checks += 4;
      if (frame_cnt !== 32'(m_frame)) begin
         n_fail++; $display("FAIL rand_frame_cnt: got %0d expected %0d", frame_cnt, m_frame);
      end
      if (err_cnt !== 32'(m_err)) begin
         n_fail++; $display("FAIL rand_err_cnt: got %0d expected %0d", err_cnt, m_err);
      end
      if (drop_cnt !== 32'(m_drop)) begin
         n_fail++; $display("FAIL rand_drop_cnt: got %0d expected %0d", drop_cnt, m_drop);
      end
      if (got_q.size() !== exp_q.size()) begin
         n_fail++; $display("FAIL rand_count: got %0d expected %0d", got_q.size(), exp_q.size());
      end
      foreach (exp_q[i]) begin
         n_checks++;
         if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
            n_fail++;
            $display("FAIL rand_word%0d: got %h expected %h", i,
                     (i < got_q.size()) ? got_q[i] : 65'h0, exp_q[i]);
         end
      end
      exp_q.delete();
      got_q.delete();
   endtask

   task automatic test_reset_mid_frame();
      m_axis_tready = 1'b0;
      send_frame(N_CH, 4, 1'b1);
      enable = 1'b1;
      s_axis_ddc_tdata = mk_raw(7, -7);
      s_axis_ddc_tvalid = 1'b1;
      tick();
      tick();
      dev_rst = 1'b1;
      s_axis_ddc_tvalid = 1'b0;
      tick();
      n_checks += 4;
      if (m_axis_tvalid !== 1'b0) begin
         n_fail++; $display("FAIL midrst_tvalid: got %b expected 0", m_axis_tvalid);
      end
      if (frame_cnt !== 32'd0) begin
         n_fail++; $display("FAIL midrst_frame_cnt: got %0d expected 0", frame_cnt);
      end
      if (drop_cnt !== 32'd0) begin
         n_fail++; $display("FAIL midrst_drop_cnt: got %0d expected 0", drop_cnt);
      end
      if (err_cnt !== 32'd0) begin
         n_fail++; $display("FAIL midrst_err_cnt: got %0d expected 0", err_cnt);
      end
      dev_rst = 1'b0;
      exp_q.delete();
      got_q.delete();
      m_frame = 0;
      m_drop = 0;
      m_err = 0;
      tick();
      m_axis_tready = 1'b1;
      send_frame(N_CH, GAP, 1'b1);
      drain();
      n_checks++;
      if (got_q.size() == 0 || got_q[0][31:0] !== 32'd0) begin
         n_fail++;
         $display("FAIL midrst_hdr: got %h expected frame number 0",
                  (got_q.size() > 0) ? got_q[0] : 65'h0);
      end
      n_checks++;
      if (got_q.size() !== exp_q.size()) begin
         n_fail++; $display("FAIL midrst_count: got %0d expected %0d", got_q.size(), exp_q.size());
      end
      foreach (exp_q[i]) begin
         n_checks++;
         if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
            n_fail++;
            $display("FAIL midrst_word%0d: got %h expected %h", i,
                     (i < got_q.size()) ? got_q[i] : 65'h0, exp_q[i]);
         end
      end
      exp_q.delete();
      got_q.delete();
   endtask

   initial begin
      dev_rst = 1'b1;
      s_axis_ddc_tdata = '0;
      s_axis_ddc_tvalid = 1'b0;
      enable = 1'b1;
      m_axis_tready = 1'b1;
      test_reset();
      test_single_frame();
      test_back_to_back();
      test_drop();
      test_truncation();
      test_overrun();
      test_random();
      test_reset_mid_frame();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/ddc_frame_packer.md
Name: ddc_frame_packer

Overview:
- Receiver for the serialized multichannel DDC result stream. That stream is N_CH contiguous 64-bit beats, one per channel, with Q in [61:32] and I in [29:0].
- The block frames each burst into a packet: one header word, then N_CH sign-extended data words. Packets go through a commit-pointer FIFO to an AXI-Stream master for DMA.
- Frames are admitted whole or not at all. A frame is dropped if there is no room for it, and discarded if it is truncated.
- Sits in the dev_clk domain, directly after the DDC accumulator sequencer.

Parameters:
- N_CH, 4: channels per frame. Range 1..256.
- FIFO_DEPTH, 64: FIFO depth in words. Must be a power of 2 and at least 2*(N_CH+2).

Ports:
- dev_clk  in  1  Single clock for the whole block.
- dev_rst  in  1  Synchronous, active-high reset.
- s_axis_ddc_tdata  in  64  [61:32] Q (30b signed), [29:0] I (30b signed). Other bits are ignored.
- s_axis_ddc_tvalid  in  1  Beat valid. There is no tready: the source cannot be stalled.
- enable  in  1  Frame acceptance enable. Sampled only in IDLE.
- m_axis_tdata  out  64  Packet word.
- m_axis_tvalid  out  1  Output word valid.
- m_axis_tready  in  1  Downstream ready.
- m_axis_tlast  out  1  High on the last word of a packet.
- frame_cnt  out  32  Frames started. Includes dropped and truncated frames.
- drop_cnt  out  32  Frames dropped for insufficient FIFO space.
- err_cnt  out  32  Protocol errors: truncations plus overruns.

Behaviour:
- Reset (dev_rst=1 at a clock edge) has priority over everything:
  - All pointers and counters are cleared to 0.
  - State goes to IDLE.
  - m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0.
  - Reset mid-frame discards all uncommitted and committed data.
- Word formats:
  - Data word: [63:32] = Q sign-extended to 32b; [31:0] = I sign-extended to 32b.
  - Header word: [63:48]=16'hDDC0, [47:32]=N_CH, [31:0]=frame_cnt value before increment. The first frame therefore carries 0.
- FIFO:
  - Entries are 65 bits: {tlast, data}.
  - Three pointers: wr_ptr, commit_ptr, rd_ptr.
  - The reader sees only words below commit_ptr.
  - free = FIFO_DEPTH - (wr_ptr - rd_ptr). Pointers wrap modulo 2*FIFO_DEPTH for the full/empty distinction.
- Input pipeline: each accepted beat is held in a one-word stage register and written into the FIFO on the following cycle.
- State IDLE, on tvalid=1:
  - frame_cnt increments whether or not enable=1.
  - If enable=0: go to SKIP.
  - Else if free >= N_CH+1: write the header at wr_ptr, stage the beat, set beat_idx=1, go to COLLECT.
  - Else: drop_cnt increments, go to SKIP.
- State COLLECT:
  - Each cycle, write the staged beat.
  - If tvalid=1: stage the new beat and increment beat_idx.
  - When beat_idx reaches N_CH: go to FLUSH.
  - If tvalid=0 with beat_idx<N_CH (truncation): set wr_ptr=commit_ptr (rewind), err_cnt increments, go to IDLE. The frame's words never become visible.
- State FLUSH:
  - Write the last staged beat with tlast=1 and set commit_ptr to the new wr_ptr.
  - If tvalid=1 in this cycle (overrun, i.e. no gap after N_CH beats): err_cnt increments and go to SKIP. The already-complete frame still commits.
  - Otherwise go to IDLE.
- State SKIP: ignore input until tvalid=0, then go to IDLE. The cycle with tvalid=0 is not a frame start.
- Input timing requirement: a minimum gap of 1 idle cycle between frames. With that gap, no frame is lost.
- Output side:
  - A registered output word is loaded from FIFO[rd_ptr] when rd_ptr != commit_ptr and (m_axis_tvalid=0 or m_axis_tready=1).
  - m_axis_tdata and m_axis_tlast are held stable while tvalid=1 and tready=0.
- Latency: when the output is idle and tready=1, the header appears on m_axis exactly 3 cycles after the cycle the last input beat was sampled. Words then follow at 1 per cycle.
- Counters wrap at 2^32.
- Simultaneous events: an FLUSH commit and an output read in the same cycle are both honoured. free uses the rd_ptr registered at the start of the cycle.

Optional Feature:
- Macro: DDC_TRAILER_EN.
- When defined:
  - A trailer word {drop_cnt, err_cnt} is appended after the last data word. The counts are those at FLUSH entry.
  - tlast moves to the trailer word.
  - An extra state TRAILER sits after FLUSH. The commit occurs in TRAILER.
  - Space check becomes free >= N_CH+2.
  - The minimum inter-frame gap is 2 cycles. tvalid=1 in TRAILER counts as an overrun.
  - Latency becomes 4 cycles.
- When undefined: packet length is N_CH+1 and behaviour is exactly as above.

Test Plan:
- Single frame, N_CH=4, beats I=1,-1,2^29-1,-2^29 with Q=-I, tready=1 -> header 0xDDC0_0004_0000_0000 at cycle+3, then sign-extended words; tlast on word 5; frame_cnt=1.
- 10 frames with 1-cycle gaps and tready=0 (FIFO_DEPTH=64 holds 12 frames) -> all 10 committed; release tready -> 50 words in order, headers 0..9.
- Keep tready=0 until free<5, then inject a frame -> drop_cnt=1, frame_cnt increments, no partial words; the next frame's header shows the skipped count.
- tvalid drops after 2 of 4 beats -> err_cnt=1, nothing emitted, wr_ptr equals commit_ptr; the following complete frame is emitted intact.
- tvalid high for 6 beats -> first 4 committed, err_cnt=1, beats 5-6 ignored, no second header.
- Assert dev_rst mid-COLLECT with committed words pending -> m_axis_tvalid=0 next cycle; all counters 0; the next frame's header is 0.
